// File: rtl/immediate_decode_stage_pkg.sv
// Shared definitions for the immediate decode stage: format select codes,
// the output-buffer state encoding and the XLEN legality check.
package immediate_decode_stage_pkg;

   localparam int unsigned SEL_W = 3;

   localparam logic [SEL_W-1:0] IMM_SEL_U = 3'b000;
   localparam logic [SEL_W-1:0] IMM_SEL_J = 3'b001;
   localparam logic [SEL_W-1:0] IMM_SEL_I = 3'b010;
   localparam logic [SEL_W-1:0] IMM_SEL_B = 3'b011;
   localparam logic [SEL_W-1:0] IMM_SEL_S = 3'b100;
   localparam logic [SEL_W-1:0] IMM_SEL_Z = 3'b101;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } stage_state_e;

   function automatic logic xlen_ok(input int unsigned xlen);
      return (xlen == 32) || (xlen == 64);
   endfunction

endpackage

// File: rtl/immediate_decode_stage_imm_extract.sv
// Combinational RV32 immediate extraction, sign-extended to XLEN.
// The CSR uimm (Z) format exists only when IMM_CSR_UIMM_EN is defined.
module imm_extract
   import immediate_decode_stage_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]      instruction,
   input  logic [SEL_W-1:0] select,
   output logic [XLEN-1:0]  imm,
   output logic             err
);

   logic [31:0] raw;
   logic        unused_opcode;

   assign unused_opcode = ^instruction[6:0];

   // raw is already a sign-correct 32-bit value; Z has bit 31 clear so it zero-extends
   always_comb begin
      raw = '0;
      err = 1'b0;
      case (select)
         IMM_SEL_U: raw = {instruction[31:12], 12'b0};
         IMM_SEL_J: raw = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                           instruction[30:21], 1'b0};
         IMM_SEL_I: raw = {{20{instruction[31]}}, instruction[31:20]};
         IMM_SEL_B: raw = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                           instruction[11:8], 1'b0};
         IMM_SEL_S: raw = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
`ifdef IMM_CSR_UIMM_EN
         IMM_SEL_Z: raw = {27'b0, instruction[19:15]};
`endif
         default: begin
            raw = '0;
            err = 1'b1;
         end
      endcase
   end

   assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/immediate_decode_stage.sv
// Registered immediate decode stage: one output register plus one skid entry
// behind a valid/ready handshake. Optional Z format via IMM_CSR_UIMM_EN.
module immediate_decode_stage
   import immediate_decode_stage_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             FLUSH,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [31:0]      INSTRUCTION,
   input  logic [2:0]       SELECT,
   input  logic [TAG_W-1:0] IN_TAG,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [XLEN-1:0]  OUT,
   output logic [TAG_W-1:0] OUT_TAG,
   output logic             FORMAT_ERR
);

   if (!xlen_ok(XLEN)) begin : g_bad_xlen
      $error("immediate_decode_stage: XLEN must be 32 or 64");
   end

   stage_state_e     state;
   logic [XLEN-1:0]  ext_imm;
   logic             ext_err;
   logic [XLEN-1:0]  skid_imm;
   logic [TAG_W-1:0] skid_tag;
   logic             skid_err;
   logic             accept;
   logic             drain;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instruction (INSTRUCTION),
      .select      (SELECT),
      .imm         (ext_imm),
      .err         (ext_err)
   );

   assign accept = IN_VALID & IN_READY;
   assign drain  = OUT_VALID & OUT_READY;

   // IN_READY is recomputed every edge from the next state, so it never sees OUT_READY combinationally
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= ST_EMPTY;
         IN_READY   <= 1'b0;
         OUT_VALID  <= 1'b0;
         OUT        <= '0;
         OUT_TAG    <= '0;
         FORMAT_ERR <= 1'b0;
         skid_imm   <= '0;
         skid_tag   <= '0;
         skid_err   <= 1'b0;
      end else if (FLUSH) begin
         state      <= ST_EMPTY;
         IN_READY   <= 1'b1;
         OUT_VALID  <= 1'b0;
         OUT        <= '0;
         OUT_TAG    <= '0;
         FORMAT_ERR <= 1'b0;
         skid_imm   <= '0;
         skid_tag   <= '0;
         skid_err   <= 1'b0;
      end else begin
         IN_READY <= 1'b1;
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  OUT        <= ext_imm;
                  OUT_TAG    <= IN_TAG;
                  FORMAT_ERR <= ext_err;
                  OUT_VALID  <= 1'b1;
                  state      <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && !drain) begin
                  skid_imm <= ext_imm;
                  skid_tag <= IN_TAG;
                  skid_err <= ext_err;
                  IN_READY <= 1'b0;
                  state    <= ST_FULL;
               end else if (accept && drain) begin
                  OUT        <= ext_imm;
                  OUT_TAG    <= IN_TAG;
                  FORMAT_ERR <= ext_err;
               end else if (drain) begin
                  OUT_VALID <= 1'b0;
                  state     <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (drain) begin
                  OUT        <= skid_imm;
                  OUT_TAG    <= skid_tag;
                  FORMAT_ERR <= skid_err;
                  state      <= ST_ONE;
               end else begin
                  IN_READY <= 1'b0;
               end
            end
            default: begin
               OUT_VALID <= 1'b0;
               state     <= ST_EMPTY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_immediate_decode_stage.sv
// Directed self-checking bench for immediate_decode_stage (XLEN=32 and XLEN=64 instances).
module tb_immediate_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [31:0] instr;
   logic [2:0]  sel;
   logic [4:0]  in_tag;
   logic        out_ready;

   logic        in_ready, out_valid, fmt_err;
   logic [31:0] out32;
   logic [4:0]  out_tag;
   logic        in_ready64, out_valid64, fmt_err64;
   logic [63:0] out64;
   logic [4:0]  out_tag64;

   int checks = 0;
   int errors = 0;

   logic [31:0] v_ins  [10];
   logic [2:0]  v_sel  [10];
   logic [31:0] v_e32  [10];
   logic [63:0] v_e64  [10];
   logic        v_err  [10];

   always #5 clk = ~clk;

   immediate_decode_stage #(.XLEN(32), .TAG_W(5)) dut (
      .CLK(clk), .RESET_N(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready),
      .INSTRUCTION(instr), .SELECT(sel), .IN_TAG(in_tag), .OUT_VALID(out_valid),
      .OUT_READY(out_ready), .OUT(out32), .OUT_TAG(out_tag), .FORMAT_ERR(fmt_err)
   );

   immediate_decode_stage #(.XLEN(64), .TAG_W(5)) dut64 (
      .CLK(clk), .RESET_N(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready64),
      .INSTRUCTION(instr), .SELECT(sel), .IN_TAG(in_tag), .OUT_VALID(out_valid64),
      .OUT_READY(out_ready), .OUT(out64), .OUT_TAG(out_tag64), .FORMAT_ERR(fmt_err64)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; sel = '0; in_tag = '0;
      out_ready = 1'b0;
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      checks++; if (out32 !== 32'h0) begin errors++; $display("FAIL reset_out: got %h expected 0", out32); end
      checks++; if (out_tag !== 5'h0) begin errors++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
      checks++; if (fmt_err !== 1'b0) begin errors++; $display("FAIL reset_format_err: got %b expected 0", fmt_err); end
      rst_n = 1'b1;
      #2;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b expected 0", in_ready); end
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b expected 0", out_valid); end
   endtask

   task automatic test_formats();
      v_ins[0] = 32'hFFF00093; v_sel[0] = 3'b010; v_e32[0] = 32'hFFFFFFFF; v_e64[0] = 64'hFFFFFFFFFFFFFFFF; v_err[0] = 1'b0;
      v_ins[1] = 32'hFE000EE3; v_sel[1] = 3'b011; v_e32[1] = 32'hFFFFFFFC; v_e64[1] = 64'hFFFFFFFFFFFFFFFC; v_err[1] = 1'b0;
      v_ins[2] = 32'h12345037; v_sel[2] = 3'b000; v_e32[2] = 32'h12345000; v_e64[2] = 64'h0000000012345000; v_err[2] = 1'b0;
      v_ins[3] = 32'h80000037; v_sel[3] = 3'b000; v_e32[3] = 32'h80000000; v_e64[3] = 64'hFFFFFFFF80000000; v_err[3] = 1'b0;
      v_ins[4] = 32'h0040006F; v_sel[4] = 3'b001; v_e32[4] = 32'h00000004; v_e64[4] = 64'h0000000000000004; v_err[4] = 1'b0;
      v_ins[5] = 32'hFFDFF06F; v_sel[5] = 3'b001; v_e32[5] = 32'hFFFFFFFC; v_e64[5] = 64'hFFFFFFFFFFFFFFFC; v_err[5] = 1'b0;
      v_ins[6] = 32'hFE112E23; v_sel[6] = 3'b100; v_e32[6] = 32'hFFFFFFFC; v_e64[6] = 64'hFFFFFFFFFFFFFFFC; v_err[6] = 1'b0;
      v_ins[7] = 32'hFFFFFFFF; v_sel[7] = 3'b110; v_e32[7] = 32'h00000000; v_e64[7] = 64'h0; v_err[7] = 1'b1;
      v_ins[8] = 32'hFFFFFFFF; v_sel[8] = 3'b111; v_e32[8] = 32'h00000000; v_e64[8] = 64'h0; v_err[8] = 1'b1;
`ifdef IMM_CSR_UIMM_EN
      v_ins[9] = 32'h000F8073; v_sel[9] = 3'b101; v_e32[9] = 32'h0000001F; v_e64[9] = 64'h1F; v_err[9] = 1'b0;
`else
      v_ins[9] = 32'h000F8073; v_sel[9] = 3'b101; v_e32[9] = 32'h00000000; v_e64[9] = 64'h0; v_err[9] = 1'b1;
`endif
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; instr = v_ins[i]; sel = v_sel[i]; in_tag = 5'(i + 1);
         tick();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fmt%0d_valid: got %b expected 1", i, out_valid); end
         checks++; if (out32 !== v_e32[i]) begin errors++; $display("FAIL fmt%0d_out32: got %h expected %h", i, out32, v_e32[i]); end
         checks++; if (out64 !== v_e64[i]) begin errors++; $display("FAIL fmt%0d_out64: got %h expected %h", i, out64, v_e64[i]); end
         checks++; if (fmt_err !== v_err[i]) begin errors++; $display("FAIL fmt%0d_err: got %b expected %b", i, fmt_err, v_err[i]); end
         checks++; if (out_tag !== 5'(i + 1)) begin errors++; $display("FAIL fmt%0d_tag: got %h expected %h", i, out_tag, 5'(i + 1)); end
      end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fmt_drained: got %b expected 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      in_valid = 1'b1; instr = 32'hFFF00093; sel = 3'b010; in_tag = 5'd1;
      tick();
      checks++; if (out_tag !== 5'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_first: got tag %h valid %b expected tag 01 valid 1", out_tag, out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one: got %b expected 1", in_ready); end
      instr = 32'h12345037; sel = 3'b000; in_tag = 5'd2;
      tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b expected 0", in_ready); end
      instr = 32'h0040006F; sel = 3'b001; in_tag = 5'd3;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d_ready: got %b expected 0", k, in_ready); end
         checks++; if (out_tag !== 5'd1 || out32 !== 32'hFFFFFFFF || fmt_err !== 1'b0 || out_valid !== 1'b1)
            begin errors++; $display("FAIL bp_hold%0d_stable: got tag %h out %h err %b valid %b expected tag 01 out ffffffff err 0 valid 1", k, out_tag, out32, fmt_err, out_valid); end
      end
      out_ready = 1'b1;
      tick();
      checks++; if (out_tag !== 5'd2 || out32 !== 32'h12345000 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain2: got tag %h out %h valid %b expected tag 02 out 12345000 valid 1", out_tag, out32, out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b expected 1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_tag !== 5'd3 || out32 !== 32'h00000004 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain3: got tag %h out %h valid %b expected tag 03 out 00000004 valid 1", out_tag, out32, out_valid); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; instr = 32'hFFF00093; sel = 3'b010; in_tag = 5'd4;
      tick();
      in_tag = 5'd5;
      tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_full: got ready %b expected 0", in_ready); end
      flush = 1'b1; in_tag = 5'd6;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_full_valid: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_full_ready: got %b expected 1", in_ready); end
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_no_stale: got %b expected 0", out_valid); end
      out_ready = 1'b0; in_valid = 1'b1; in_tag = 5'd7;
      tick();
      flush = 1'b1; in_tag = 5'd8;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_one_drop: got valid %b expected 0", out_valid); end
      in_valid = 1'b1; in_tag = 5'd9; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_tag !== 5'd9) begin errors++; $display("FAIL fl_resume: got valid %b tag %h expected 1 tag 09", out_valid, out_tag); end
      tick();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid = 1'b1; instr = 32'h12345037; sel = 3'b000; in_tag = 5'd10;
      tick();
      in_tag = 5'd11;
      tick();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid_now: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_now: got %b expected 0", in_ready); end
      checks++; if (out32 !== 32'h0 || out_tag !== 5'h0) begin errors++; $display("FAIL rm_payload: got out %h tag %h expected 0 0", out32, out_tag); end
      tick();
      rst_n = 1'b1; out_ready = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_ready_release: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_stale1: got %b expected 0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_stale2: got %b expected 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_formats();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/immediate_decode_stage.md
IMMEDIATE_DECODE_STAGE -- requirements
Module: immediate_decode_stage

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, output width (32 or 64 only); TAG_W, default 5, sideband tag width.
REQ-002 Ports SHALL be:
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous, active-low reset.
- FLUSH  in  1  synchronous pipeline flush.
- IN_VALID  in  1  input beat valid.
- IN_READY  out  1  stage can accept a beat.
- INSTRUCTION  in  32  raw instruction.
- SELECT  in  3  format select.
- IN_TAG  in  TAG_W  sideband, e.g. rd index.
- OUT_VALID  out  1  output beat valid.
- OUT_READY  in  1  consumer accepts.
- OUT  out  XLEN  extended immediate.
- OUT_TAG  out  TAG_W  tag travelling with OUT.
- FORMAT_ERR  out  1  illegal SELECT for this beat.
REQ-003 The design SHALL have one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 SELECT encoding SHALL be: 000 U, 001 J, 010 I, 011 B, 100 S, 101 Z (CSR uimm, INSTRUCTION[19:15] zero-extended, macro only), others illegal.
REQ-005 U/J/I/B/S immediates SHALL use the RV32 bit placement and SHALL be sign-extended from INSTRUCTION[31] to XLEN; for XLEN=64, U SHALL sign-extend bit 31.
REQ-006 An illegal SELECT SHALL produce OUT=0 with FORMAT_ERR=1; the beat SHALL still be transferred.
REQ-007 A beat SHALL transfer on the input when IN_VALID&IN_READY, and on the output when OUT_VALID&OUT_READY.
REQ-008 Latency SHALL be 1 cycle: a beat accepted at edge N SHALL appear on OUT at edge N when the output register is empty or drains at N.
REQ-009 Storage SHALL be a main output register plus one skid register, controlled by states EMPTY, ONE and FULL.
REQ-010 Transitions:
- EMPTY --accept--> ONE.
- ONE --accept & !drain--> FULL (beat into skid).
- ONE --drain & !accept--> EMPTY.
- ONE --accept & drain--> ONE.
- FULL --drain--> ONE (skid moves to main).
REQ-011 IN_READY SHALL be a registered output equal to (state != FULL); there SHALL be no combinational path from OUT_READY to IN_READY.
REQ-012 OUT, OUT_TAG and FORMAT_ERR SHALL hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-013 FLUSH SHALL move the stage to EMPTY at the next edge and discard both entries; an input beat offered in that cycle SHALL be dropped.
REQ-014 Beat order SHALL be preserved; no beat is duplicated or lost except by FLUSH or reset.

Reset
REQ-015 While RESET_N=0, the stage SHALL be in EMPTY with OUT_VALID=0, IN_READY=0, OUT=0, OUT_TAG=0 and FORMAT_ERR=0.
REQ-016 IN_READY SHALL rise at the first rising edge after RESET_N deasserts.
REQ-017 Reset asserted mid-transfer SHALL discard all held beats immediately, with no wait for a clock edge.

Configuration
REQ-018 With macro IMM_CSR_UIMM_EN defined, SELECT=101 SHALL yield the Z immediate with FORMAT_ERR=0.
REQ-019 Without IMM_CSR_UIMM_EN, SELECT=101 SHALL be illegal per REQ-006.

Structure
REQ-020 A shared package SHALL hold the SELECT encoding constants (IMM_SEL_U ... IMM_SEL_Z), the state enum and the XLEN legality check.
REQ-021 Extraction SHALL live in a combinational sub-module imm_extract (INSTRUCTION, SELECT -> XLEN value, error flag).
REQ-022 immediate_decode_stage SHALL own only the registers and the handshake.

Verification
REQ-023 XLEN=32, SELECT=010, INSTRUCTION=32'hFFF00093, OUT_READY=1 -> next edge OUT=32'hFFFFFFFF, OUT_VALID=1, FORMAT_ERR=0.
REQ-024 SELECT=011, INSTRUCTION=32'hFE000EE3 -> OUT=32'hFFFFFFFC; SELECT=000, INSTRUCTION=32'h12345037 -> OUT=32'h12345000.
REQ-025 XLEN=64, SELECT=000, INSTRUCTION=32'h80000037 -> OUT=64'hFFFFFFFF80000000.
REQ-026 Backpressure:
- Stimulus: OUT_READY=0, three back-to-back beats with tags 1, 2, 3.
- Required: two beats accepted, IN_READY=0 from the edge after the second.
- Then OUT_READY=1: tags 1, 2, 3 emerge in order, with no bubble once draining.
REQ-027 SELECT=101 with INSTRUCTION[19:15]=5'h1F -> OUT=32'h1F with the macro defined; without it, OUT=0 and FORMAT_ERR=1.
REQ-028 State FULL, then FLUSH=1 for one cycle -> OUT_VALID=0 next edge.
REQ-029 RESET_N low mid-cycle in state FULL -> OUT_VALID=0 and IN_READY=0 immediately, with no stale beat after release.
